// File: rtl/apb_spi_pkg.sv
// Shared definitions for the APB_SPI slave path: RAM command opcodes,
// frame geometry and the serial front-end state encoding.
package apb_spi_pkg;

    localparam int DATA_W  = 8;
    localparam int FRAME_W = DATA_W + 2;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHK_CMD   = 3'd1,
        ST_WRITE     = 3'd2,
        ST_READ_ADD  = 3'd3,
        ST_READ_DATA = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_slave_if.sv
// SPI slave front end: deserialises MOSI frames into RAM command words and
// shifts the RAM's read byte back out on MISO after a read-data frame.
module spi_slave_if
    import apb_spi_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    output logic [DATA_WIDTH+1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid
);

    localparam int         FW         = DATA_WIDTH + 2;
    localparam int         TCW        = $clog2(DATA_WIDTH);
    localparam logic [3:0] LAST_BIT   = 4'(FW - 1);
    localparam logic [3:0] FRAME_DONE = 4'(FW);

    spi_state_e            state_q, state_d;
    logic [FW-2:0]         shreg_q, shreg_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [FW-1:0]         rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rd_addr_seen_q, rd_addr_seen_d;
    logic                  tx_latched_q, tx_latched_d;
    logic                  tx_active_q, tx_active_d;
    logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [TCW-1:0]        tx_cnt_q, tx_cnt_d;
    logic                  miso_q, miso_d;

    always_comb begin
        state_d        = state_q;
        shreg_d        = shreg_q;
        cnt_d          = cnt_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rd_addr_seen_d = rd_addr_seen_q;
        tx_latched_d   = tx_latched_q;
        tx_active_d    = tx_active_q;
        tx_sh_d        = tx_sh_q;
        tx_cnt_d       = tx_cnt_q;
        miso_d         = miso_q;

        if (SS_n) begin
            // Frame end or abort: partial frames are dropped silently.
            state_d      = ST_IDLE;
            cnt_d        = 4'd0;
            tx_latched_d = 1'b0;
            tx_active_d  = 1'b0;
            miso_d       = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_CHK_CMD;
                end
                ST_CHK_CMD: begin
                    shreg_d = {shreg_q[FW-3:0], MOSI};
                    cnt_d   = 4'd1;
                    if (!MOSI)
                        state_d = ST_WRITE;
                    else if (rd_addr_seen_q)
                        state_d = ST_READ_DATA;
                    else
                        state_d = ST_READ_ADD;
                end
                ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
                    if (cnt_q < FRAME_DONE) begin
                        shreg_d = {shreg_q[FW-3:0], MOSI};
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == LAST_BIT) begin
                            rx_data_d  = {shreg_q, MOSI};
                            rx_valid_d = 1'b1;
                            if (state_q == ST_READ_ADD && shreg_q[FW-2 -: 2] == OP_RD_ADDR)
                                rd_addr_seen_d = 1'b1;
                            if (state_q == ST_READ_DATA)
                                rd_addr_seen_d = 1'b0;
                        end
                    end else if (state_q == ST_READ_DATA) begin
                        // Readback: first tx_valid after the rx_valid strobe is
                        // captured once; the byte goes out MSB first.
                        if (tx_active_q) begin
                            if (tx_cnt_q != '0) begin
                                miso_d   = tx_sh_q[DATA_WIDTH-1];
                                tx_sh_d  = tx_sh_q << 1;
                                tx_cnt_d = tx_cnt_q - 1'b1;
                            end else begin
                                miso_d      = 1'b0;
                                tx_active_d = 1'b0;
                            end
                        end else if (!tx_latched_q && !rx_valid_q && tx_valid) begin
                            tx_latched_d = 1'b1;
                            tx_active_d  = 1'b1;
                            miso_d       = tx_data[DATA_WIDTH-1];
                            tx_sh_d      = tx_data << 1;
                            tx_cnt_d     = TCW'(DATA_WIDTH - 1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cnt_q          <= 4'd0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rd_addr_seen_q <= 1'b0;
            tx_latched_q   <= 1'b0;
            tx_active_q    <= 1'b0;
            tx_cnt_q       <= '0;
            miso_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rd_addr_seen_q <= rd_addr_seen_d;
            tx_latched_q   <= tx_latched_d;
            tx_active_q    <= tx_active_d;
            tx_cnt_q       <= tx_cnt_d;
            miso_q         <= miso_d;
        end
    end

    // Pure data shifters; their contents are only consumed under control qualifiers.
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
        tx_sh_q <= tx_sh_d;
    end

    assign MISO     = miso_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: table of SPI frames with expected command words and
// readback bytes; a queue scoreboard pairs every rx_valid with its frame.
module tb_spi_slave_if;

    logic       clk;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_vec = 0;
    int n_bad = 0;
    logic [9:0] rxq[$];
    logic [9:0] rx_exp;

    typedef struct {
        logic [9:0] frame;
        int         nbits;
        logic [9:0] exp_rx;
        bit         exp_rd;
        logic [7:0] txb;
        int         hold;
        int         cut_c;
        bit         cut_rst;
    } vec_t;

    vec_t vt[16];

    spi_slave_if #(.DATA_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && rx_valid === 1'b1) begin
            if (rxq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL rx_unexpected: rx_data=0x%0h, want no strobe (t=%0t)", rx_data, $time);
            end else begin
                rx_exp = rxq.pop_front();
                check("rx_data", {22'd0, rx_data}, {22'd0, rx_exp});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic expm;
        int   cmax;
        @(negedge clk);
        SS_n = 1'b0;
        MOSI = 1'b0;
        for (int b = 0; b < v.nbits; b++) begin
            @(negedge clk);
            check("miso_in_frame", {31'd0, MISO}, 32'd0);
            MOSI = v.frame[9-b];
        end
        if (v.nbits == 10) rxq.push_back(v.exp_rx);
        @(negedge clk);
        if (v.nbits < 10) begin
            SS_n = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check("rx_valid_abort", {31'd0, rx_valid}, 32'd0);
            end
            return;
        end
        check("rx_valid_latency", {31'd0, rx_valid}, 32'd1);
        cmax = (v.hold + 1 > 11) ? v.hold + 1 : 11;
        for (int c = 0; c <= cmax; c++) begin
            @(negedge clk);
            expm = (v.exp_rd && c >= 1 && c <= 8) ? v.txb[8-c] : 1'b0;
            check("miso_readback", {31'd0, MISO}, {31'd0, expm});
            check("rx_valid_single", {31'd0, rx_valid}, 32'd0);
            MOSI     = 1'($urandom);
            tx_data  = v.txb;
            tx_valid = (c < v.hold);
            if (v.cut_c != 0 && c == v.cut_c) begin
                if (v.cut_rst) begin
                    #2;
                    rst_n    = 1'b0;
                    SS_n     = 1'b1;
                    tx_valid = 1'b0;
                    #1;
                    check("miso_rst", {31'd0, MISO}, 32'd0);
                    check("rx_valid_rst", {31'd0, rx_valid}, 32'd0);
                    check("rx_data_rst", {22'd0, rx_data}, 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                end else begin
                    SS_n     = 1'b1;
                    tx_valid = 1'b0;
                    @(negedge clk);
                    check("miso_ss_clr", {31'd0, MISO}, 32'd0);
                end
                @(negedge clk);
                return;
            end
        end
        @(negedge clk);
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want finish before %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        //          frame    nbits exp_rx  rd  txb    hold cut rst
        vt[0]  = '{10'h005, 10, 10'h005, 1'b0, 8'h00, 1,  0, 1'b0};
        vt[1]  = '{10'h1AA, 10, 10'h1AA, 1'b0, 8'h00, 0,  0, 1'b0};
        vt[2]  = '{10'h205, 10, 10'h205, 1'b0, 8'h00, 1,  0, 1'b0};
        vt[3]  = '{10'h3C3, 10, 10'h3C3, 1'b1, 8'hA5, 1,  0, 1'b0};
        vt[4]  = '{10'h3FF, 10, 10'h3FF, 1'b0, 8'hFF, 1,  0, 1'b0};
        vt[5]  = '{10'h0F0, 6,  10'h000, 1'b0, 8'h00, 0,  0, 1'b0};
        vt[6]  = '{10'h0F0, 10, 10'h0F0, 1'b0, 8'h00, 0,  0, 1'b0};
        vt[7]  = '{10'h2AB, 10, 10'h2AB, 1'b0, 8'h00, 0,  0, 1'b0};
        vt[8]  = '{10'h155, 10, 10'h155, 1'b0, 8'h77, 1,  0, 1'b0};
        vt[9]  = '{10'h300, 10, 10'h300, 1'b1, 8'h3C, 20, 0, 1'b0};
        vt[10] = '{10'h210, 10, 10'h210, 1'b0, 8'h00, 0,  0, 1'b0};
        vt[11] = '{10'h3E7, 10, 10'h3E7, 1'b1, 8'h81, 1,  4, 1'b0};
        vt[12] = '{10'h222, 10, 10'h222, 1'b0, 8'h00, 0,  0, 1'b0};
        vt[13] = '{10'h3AA, 10, 10'h3AA, 1'b1, 8'h5A, 1,  3, 1'b1};
        vt[14] = '{10'h300, 10, 10'h300, 1'b0, 8'hC3, 1,  0, 1'b0};
        vt[15] = '{10'h001, 10, 10'h001, 1'b0, 8'h00, 0,  0, 1'b0};

        repeat (2) @(negedge clk);
        check("reset_miso", {31'd0, MISO}, 32'd0);
        check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("reset_rx_data", {22'd0, rx_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) run_vec(vt[i]);

        repeat (3) @(negedge clk);
        check("rxq_drained", rxq.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
